// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART front end: CPU stores feed a TX FIFO drained into the serializer,
// received bytes are queued in an RX FIFO popped by CPU loads.
module uart_mmio_bridge #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
   parameter int          FIFO_DEPTH = 16,
   parameter int          PTR_W      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic [31:0] rdata,
   output logic        rd_sel,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   input  logic        tx_busy,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;

   localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

   logic [7:0]       tx_mem [FIFO_DEPTH];
   logic [7:0]       rx_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] tx_head_reg, tx_tail_reg, rx_head_reg, rx_tail_reg;
   logic [PTR_W:0]   tx_count_reg, rx_count_reg;
   logic             rx_overrun_reg, tx_drop_reg;
   state_t           state_reg;
   logic             tx_start_reg;
   logic [7:0]       tx_byte_reg;

   logic       hit;
   logic [1:0] reg_idx;
   logic       wr_tx, wr_ctrl, rd_rx, flush, clear_sticky;
   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       tx_push, tx_pop, rx_push, rx_pop;
   logic       unused_bits;

   // Word-aligned decode; the byte offset within a word is ignored.
   assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
   assign reg_idx = addr[3:2];
   assign unused_bits = &{1'b0, addr[1:0], wdata[31:8]};

   assign rd_sel       = mem_read & hit & reset;
   assign wr_tx        = mem_write & hit & (reg_idx == 2'd0);
   assign wr_ctrl      = mem_write & hit & (reg_idx == 2'd3);
   assign rd_rx        = rd_sel & (reg_idx == 2'd1);
   assign flush        = wr_ctrl & wdata[1];
   assign clear_sticky = wr_ctrl & wdata[0];

   assign tx_full  = (tx_count_reg == DEPTH_C);
   assign tx_empty = (tx_count_reg == '0);
   assign rx_full  = (rx_count_reg == DEPTH_C);
   assign rx_empty = (rx_count_reg == '0);

   assign tx_push = wr_tx & ~tx_full;
   assign tx_pop  = (state_reg == IDLE) & ~tx_empty & ~tx_busy;
   assign rx_push = rx_valid & ~rx_full;
   assign rx_pop  = rd_rx & ~rx_empty;

   assign tx_start = tx_start_reg;
   assign tx_byte  = tx_byte_reg;
   assign irq      = ~rx_empty | rx_overrun_reg;

   always_comb begin
      rdata = '0;
      if (rd_sel) begin
         case (reg_idx)
            2'd1: if (!rx_empty) rdata = {24'h0, rx_mem[rx_head_reg]};
            2'd2: rdata = {25'h0, tx_drop_reg, (state_reg != IDLE), rx_overrun_reg,
                           rx_full, rx_empty, tx_empty, tx_full};
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push && !flush) tx_mem[tx_tail_reg] <= wdata[7:0];
      if (rx_push && !flush) rx_mem[rx_tail_reg] <= rx_byte;
   end

   // Flush overrides any push or pop landing on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_head_reg  <= '0;
         tx_tail_reg  <= '0;
         tx_count_reg <= '0;
         rx_head_reg  <= '0;
         rx_tail_reg  <= '0;
         rx_count_reg <= '0;
      end else if (flush) begin
         tx_head_reg  <= '0;
         tx_tail_reg  <= '0;
         tx_count_reg <= '0;
         rx_head_reg  <= '0;
         rx_tail_reg  <= '0;
         rx_count_reg <= '0;
      end else begin
         if (tx_push) tx_tail_reg <= tx_tail_reg + 1'b1;
         if (tx_pop)  tx_head_reg <= tx_head_reg + 1'b1;
         if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + 1'b1;
         else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - 1'b1;
         if (rx_push) rx_tail_reg <= rx_tail_reg + 1'b1;
         if (rx_pop)  rx_head_reg <= rx_head_reg + 1'b1;
         if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + 1'b1;
         else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_drop_reg    <= 1'b0;
         rx_overrun_reg <= 1'b0;
      end else begin
         tx_drop_reg    <= (tx_drop_reg & ~clear_sticky) | (wr_tx & tx_full);
         rx_overrun_reg <= (rx_overrun_reg & ~clear_sticky) | (rx_valid & rx_full);
      end
   end

   // A flush never aborts the byte already handed to the serializer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         tx_start_reg <= 1'b0;
         tx_byte_reg  <= 8'h00;
      end else begin
         case (state_reg)
            IDLE: begin
               tx_start_reg <= 1'b0;
               if (tx_pop && !flush) begin
                  tx_byte_reg  <= tx_mem[tx_head_reg];
                  tx_start_reg <= 1'b1;
                  state_reg    <= START;
               end
            end
            START: begin
               tx_start_reg <= 1'b0;
               state_reg    <= ACK;
            end
            ACK: if (tx_busy) state_reg <= DRAIN;
            DRAIN: if (!tx_busy) state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
